// File: rtl/uncached_data_bridge.sv
// -----------------------------------------------------------------------------
// uncached_data_bridge
//
// Turns one uncached CPU data request (undcache_*) into a single-beat
// AXI4-Lite read or write on the system bus. It completes the request with a
// one-cycle ready pulse that carries the read data and a bus-error flag. Only
// one access is in flight at a time. The only storage is the latched request.
//
// Ports
//   clk, rst                   clock; asynchronous active-low reset
//   undcache_en_i              request valid (held by the CPU until ready)
//   undcache_byte_en_i [3:0]   nonzero = write strobes, zero = read
//   undcache_rw_addr_i [31:0]  physical address (passed through unmodified)
//   undcache_write_data_i[31:0] write data
//   undcache_ready_o           one-cycle completion pulse
//   undcache_read_data_o[31:0] read data, valid with ready (0 for writes)
//   undcache_bus_err_o         high with ready when xRESP != OKAY
//   ar*/r*/aw*/w*/b*           AXI4-Lite manager channels; all outputs registered
// -----------------------------------------------------------------------------
module uncached_data_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        undcache_en_i,
    input  logic [3:0]  undcache_byte_en_i,
    input  logic [31:0] undcache_rw_addr_i,
    input  logic [31:0] undcache_write_data_i,
    output logic        undcache_ready_o,
    output logic [31:0] undcache_read_data_o,
    output logic        undcache_bus_err_o,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_e;

    state_e              state_q,   state_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic [3:0]          strb_q,    strb_d;
    logic [DATA_W-1:0]   rdata_q,   rdata_d;
    logic                err_q,     err_d;
    logic                ready_q,   ready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q,  rready_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q,  wvalid_d;
    logic                bready_q,  bready_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q,  w_done_d;

    logic aw_fire;
    logic w_fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Every bus output is a register, so the next-state logic computes the
    // value each output must carry in the following state.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        ready_d   = 1'b0;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        aw_fire = awvalid_q && awready;
        w_fire  = wvalid_q && wready;

        case (state_q)
            IDLE: begin
                if (undcache_en_i) begin
                    addr_d  = undcache_rw_addr_i;
                    wdata_d = undcache_write_data_i;
                    strb_d  = undcache_byte_en_i;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (undcache_byte_en_i == 4'b0000) begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end
                end
            end

            RD_ADDR: begin
                if (arvalid_q && arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end

            RD_DATA: begin
                if (rvalid) begin
                    rready_d = 1'b0;
                    rdata_d  = rdata;
                    err_d    = (rresp != 2'b00);
                    ready_d  = 1'b1;
                    state_d  = DONE;
                end
            end

            // AW and W complete independently; a handshake in this cycle
            // counts together with one already recorded in the done flags.
            WR_REQ: begin
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_fire) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end

            WR_RESP: begin
                if (bvalid) begin
                    bready_d = 1'b0;
                    err_d    = (bresp != 2'b00);
                    ready_d  = 1'b1;
                    state_d  = DONE;
                end
            end

            // ready is high during this state. Data and err clear on exit so
            // they only show up alongside the pulse.
            DONE: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign undcache_ready_o     = ready_q;
    assign undcache_read_data_o = rdata_q;
    assign undcache_bus_err_o   = err_q;

    assign araddr  = addr_q;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;
    assign awaddr  = addr_q;
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = strb_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;

endmodule

// File: doc/uncached_data_bridge.md
# uncached_data_bridge

Responder for the uncached data path produced by the memory top. It takes the `undcache_*` request (enable, byte enables, physical address, write data), runs one single-beat AXI4-Lite read or write on the system bus, and returns a one-cycle ready pulse with read data to the CPU. It handles one outstanding access at a time and owns no buffering beyond the latched request.

## Interface
- No parameters; widths from `ADDR_BUS`/`DATA_BUS` in `bus.v` (32 bits each).
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `undcache_en_i` in 1: request valid; held stable by the CPU until ready.
- `undcache_byte_en_i` in 4: nonzero = write with these strobes; zero = read.
- `undcache_rw_addr_i` in 32: physical address.
- `undcache_write_data_i` in 32: write data.
- `undcache_ready_o` out 1: one-cycle completion pulse.
- `undcache_read_data_o` out 32: read data; valid while ready is high.
- `undcache_bus_err_o` out 1: high with ready when xRESP != OKAY.
- `araddr` out 32, `arvalid` out 1, `arready` in 1: read address channel.
- `rdata` in 32, `rresp` in 2, `rvalid` in 1, `rready` out 1: read data channel.
- `awaddr` out 32, `awvalid` out 1, `awready` in 1: write address channel.
- `wdata` out 32, `wstrb` out 4, `wvalid` out 1, `wready` in 1: write data channel.
- `bresp` in 2, `bvalid` in 1, `bready` out 1: write response channel.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE with en=1: latch addr, data, and byte_en. If byte_en==0, go to RD_ADDR; otherwise go to WR_REQ.
- RD_ADDR: arvalid=1 and araddr=latched addr. On arready, go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata into the read-data register, set err = (rresp!=0), and go to DONE.
- WR_REQ: awvalid and wvalid are raised together. Each one drops independently after its own handshake; track this with `aw_done`/`w_done` flags. Go to WR_RESP when both are done, including both in the same cycle.
- WR_RESP: bready=1. On bvalid, set err = (bresp!=0) and go to DONE.
- DONE: ready=1 for exactly one cycle, then go to IDLE. read_data and err are driven from registers. For writes, read_data holds 0.
- Addresses pass through unmodified; no alignment or sign extension. The CPU extracts bytes and halfwords.
- All bus outputs are registered and decoded from state. Valid signals never drop before their handshake completes.

## Timing
- Reset values: ready=0, bus_err=0, read_data=0, all valid/ready outputs 0, addresses/data/strb 0, state IDLE.
- Acceptance edge is T0. With zero-wait slaves (arready and rvalid immediate), a read asserts ready in cycle T0+3. A write with awready, wready, and bvalid immediate asserts ready in cycle T0+3.
- Each slave wait cycle adds exactly one cycle of latency.
- en is ignored in every state except IDLE. After ready, the earliest next acceptance is the cycle after DONE. The CPU must drop or change the request in the cycle after ready, otherwise the request is re-issued.
- Request inputs are sampled only at acceptance. Changes while busy have no effect.
- rvalid or bvalid arriving outside RD_DATA/WR_RESP are ignored, since rready/bready are low.
- If rst asserts mid-transaction, everything returns to reset values immediately. The bus violation this causes is accepted because reset is system-wide.

## Test plan
- Read, zero-wait: en=1, byte_en=0, addr=0x1FC0_0010, slave returns rdata=0xDEADBEEF with rresp=0 -> araddr=0x1FC0_0010, ready=1 at T0+3, read_data=0xDEADBEEF, bus_err=0.
- Write, AW before W: byte_en=4'b0011, addr=0x1FAF_F004, data=0x0000_1234; awready comes at T0+1 and wready at T0+4 -> wstrb=0011, awvalid dropped after T0+1, wvalid held through T0+4, bvalid at T0+5 -> ready at T0+6.
- Write, W before AW: wready at T0+1, awready at T0+3 -> wvalid drops first and awvalid is held. bready rises only after both handshakes; ready comes one cycle after bvalid.
- Error response: read with rresp=2'b10 -> ready pulse with bus_err=1. The next read with OKAY -> bus_err=0.
- Back-to-back: CPU keeps en=1 with new addr 0x1FAF_F008 in the cycle after ready -> a second read is accepted in IDLE, with no duplicate of the first address on araddr.
- Reset mid-read: rst low while in RD_DATA -> all outputs 0 immediately. After release, a fresh read completes normally.
